// File: rtl/uart_cmd_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : uart_cmd_pkg                                                   |
// | Purpose  : Shared types and constants for the UART command controller:   |
// |            frame state encoding, error codes and response bytes.         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ADDR   = 3'd1,
      LEN    = 3'd2,
      DATA   = 3'd3,
      CSUM   = 3'd4,
      COMMIT = 3'd5,
      RESP   = 3'd6
   } state_t;

   localparam logic [1:0] ERR_LEN     = 2'd1;
   localparam logic [1:0] ERR_CSUM    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   localparam logic [7:0] ACK_BYTE = 8'h06;
   localparam logic [7:0] NAK_BYTE = 8'h15;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_buf.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : uart_cmd_buf                                                   |
// | Purpose  : Payload buffer, DEPTH x 8. Synchronous write port filled while |
// |            the frame payload arrives, asynchronous read port drained     |
// |            during the commit burst.                                      |
// | Ports    : i_clk            clock                                         |
// |            i_we/i_waddr/i_wdata   write port                              |
// |            i_raddr/o_rdata        combinational read port                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uart_cmd_buf
   import uart_cmd_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [7:0]    i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [7:0]    o_rdata
);

   // Contents need no reset: every entry read during a commit was written
   // earlier in the same frame.
   logic [7:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : uart_cmd_ctrl                                                  |
// | Purpose  : Frames the uart_rx byte stream (SYNC ADDR LEN payload CSUM),   |
// |            checks the XOR checksum, commits the payload as a burst of    |
// |            register writes and answers with ACK/NAK on the tx path.      |
// | Ports    : i_clk, i_reset (async, active-high)                            |
// |            i_rx_data/i_rx_valid      byte stream from uart_rx             |
// |            o_reg_addr/o_reg_wdata/o_reg_we   register write bus          |
// |            o_tx_data/o_tx_valid/i_tx_ready   response handshake          |
// |            o_busy, o_err, o_err_code, o_overrun   status                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uart_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter int         CLK_FREQ     = 50000000,
   parameter int         CLK_PER_BIT  = 5208,
   parameter int         MAX_LEN      = 16,
   parameter int         TIMEOUT_BITS = 30,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [7:0] i_rx_data,
   input  logic       i_rx_valid,
   output logic [7:0] o_reg_addr,
   output logic [7:0] o_reg_wdata,
   output logic       o_reg_we,
   output logic [7:0] o_tx_data,
   output logic       o_tx_valid,
   input  logic       i_tx_ready,
   output logic       o_busy,
   output logic       o_err,
   output logic [1:0] o_err_code,
   output logic       o_overrun
);

   localparam int TO_LIMIT = CLK_PER_BIT * TIMEOUT_BITS;
   localparam int TO_W     = $clog2(TO_LIMIT);
   localparam int LW       = $clog2(MAX_LEN + 1);           // holds 0..MAX_LEN
   localparam int BW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   if (MAX_LEN < 1 || MAX_LEN > 255 || CLK_FREQ <= 0) begin : g_bad_param
      $error("uart_cmd_ctrl: MAX_LEN must be 1..255 and CLK_FREQ positive");
   end

   state_t          r_state;
   state_t          w_state_next;
   logic [7:0]      r_addr;
   logic [7:0]      r_csum;
   logic [LW-1:0]   r_len;
   logic [LW-1:0]   r_idx;        // payload index in DATA, write index in COMMIT
   logic [TO_W-1:0] r_to_cnt;
   logic            w_frame_st;
   logic            w_to_hit;
   logic            w_err;
   logic [1:0]      w_err_code;
   logic            w_buf_we;
   logic            w_tx_load;
   logic [7:0]      w_tx_byte;
   logic [7:0]      w_rd_data;

   uart_cmd_buf #(
      .DEPTH (MAX_LEN),
      .AW    (BW)
   ) u_buf (
      .i_clk   (i_clk),
      .i_we    (w_buf_we),
      .i_waddr (r_idx[BW-1:0]),
      .i_wdata (i_rx_data),
      .i_raddr (r_idx[BW-1:0]),
      .o_rdata (w_rd_data)
   );

   assign w_frame_st = (r_state == ADDR) || (r_state == LEN) ||
                       (r_state == DATA) || (r_state == CSUM);
   assign w_to_hit   = w_frame_st && !i_rx_valid &&
                       (r_to_cnt == TO_W'(TO_LIMIT - 1));

   // Next-state and per-cycle strobes
   always_comb begin
      w_state_next = r_state;
      w_err        = 1'b0;
      w_err_code   = o_err_code;
      w_buf_we     = 1'b0;
      w_tx_load    = 1'b0;
      w_tx_byte    = ACK_BYTE;
      if (w_to_hit) begin
         // Stalled frame is abandoned silently: no response, no writes.
         w_state_next = IDLE;
         w_err        = 1'b1;
         w_err_code   = ERR_TIMEOUT;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_rx_valid && i_rx_data == SYNC_BYTE) begin
                  w_state_next = ADDR;
               end
            end
            ADDR: begin
               if (i_rx_valid) begin
                  w_state_next = LEN;
               end
            end
            LEN: begin
               if (i_rx_valid) begin
                  if (i_rx_data == 8'd0 || i_rx_data > 8'(MAX_LEN)) begin
                     w_state_next = RESP;
                     w_err        = 1'b1;
                     w_err_code   = ERR_LEN;
                     w_tx_load    = 1'b1;
                     w_tx_byte    = NAK_BYTE;
                  end else begin
                     w_state_next = DATA;
                  end
               end
            end
            DATA: begin
               if (i_rx_valid) begin
                  w_buf_we = 1'b1;
                  if (r_idx == r_len - 1'b1) begin
                     w_state_next = CSUM;
                  end
               end
            end
            CSUM: begin
               if (i_rx_valid) begin
                  if (i_rx_data == r_csum) begin
                     w_state_next = COMMIT;
                  end else begin
                     w_state_next = RESP;
                     w_err        = 1'b1;
                     w_err_code   = ERR_CSUM;
                     w_tx_load    = 1'b1;
                     w_tx_byte    = NAK_BYTE;
                  end
               end
            end
            COMMIT: begin
               if (r_idx == r_len) begin
                  w_state_next = RESP;
                  w_tx_load    = 1'b1;
               end
            end
            RESP: begin
               if (i_tx_ready) begin
                  w_state_next = IDLE;
               end
            end
            default: w_state_next = IDLE;
         endcase
      end
   end

   // State register, datapath and registered outputs
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= IDLE;
         r_addr      <= 8'd0;
         r_csum      <= 8'd0;
         r_len       <= '0;
         r_idx       <= '0;
         r_to_cnt    <= '0;
         o_reg_addr  <= 8'd0;
         o_reg_wdata <= 8'd0;
         o_reg_we    <= 1'b0;
         o_tx_data   <= 8'd0;
         o_tx_valid  <= 1'b0;
         o_busy      <= 1'b0;
         o_err       <= 1'b0;
         o_err_code  <= 2'd0;
         o_overrun   <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         o_busy     <= (w_state_next != IDLE);
         o_err      <= w_err;
         o_err_code <= w_err_code;
         o_overrun  <= i_rx_valid && (r_state == COMMIT || r_state == RESP);
         o_reg_we   <= 1'b0;

         if (w_to_hit || !w_frame_st || i_rx_valid) begin
            r_to_cnt <= '0;
         end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end

         case (r_state)
            IDLE: begin
               if (w_state_next == ADDR) begin
                  r_csum <= 8'd0;
               end
            end
            ADDR: begin
               if (i_rx_valid) begin
                  r_addr <= i_rx_data;
                  r_csum <= r_csum ^ i_rx_data;
               end
            end
            LEN: begin
               if (i_rx_valid) begin
                  r_len  <= LW'(i_rx_data);
                  r_csum <= r_csum ^ i_rx_data;
                  r_idx  <= '0;
               end
            end
            DATA: begin
               if (i_rx_valid) begin
                  r_csum <= r_csum ^ i_rx_data;
                  // Rewind so CSUM already presents buffer[0] on the read port.
                  r_idx  <= (w_state_next == CSUM) ? '0 : r_idx + 1'b1;
               end
            end
            CSUM: begin
               // First write is issued on the checksum strobe itself so it
               // appears on the bus the very next cycle.
               if (w_state_next == COMMIT) begin
                  o_reg_we    <= 1'b1;
                  o_reg_addr  <= r_addr;
                  o_reg_wdata <= w_rd_data;
                  r_idx       <= LW'(1);
               end
            end
            COMMIT: begin
               if (r_idx != r_len) begin
                  o_reg_we    <= 1'b1;
                  o_reg_addr  <= r_addr + 8'(r_idx);
                  o_reg_wdata <= w_rd_data;
                  r_idx       <= r_idx + 1'b1;
               end
            end
            default: ;
         endcase

         if (w_tx_load) begin
            o_tx_valid <= 1'b1;
            o_tx_data  <= w_tx_byte;
         end else if (r_state == RESP && i_tx_ready) begin
            o_tx_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_cmd_ctrl                                               |
// | Purpose  : Scoreboard bench for uart_cmd_ctrl. Expected writes, response |
// |            bytes and error codes are queued as frames are driven and     |
// |            popped by a monitor when the DUT produces them.               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_uart_cmd_ctrl;

   localparam int CPB    = 4;
   localparam int TOB    = 30;
   localparam int MAXL   = 16;
   localparam int TO_CYC = CPB * TOB;

   logic       i_clk = 1'b0;
   logic       i_reset;
   logic [7:0] i_rx_data;
   logic       i_rx_valid;
   logic       i_tx_ready;
   logic [7:0] o_reg_addr;
   logic [7:0] o_reg_wdata;
   logic       o_reg_we;
   logic [7:0] o_tx_data;
   logic       o_tx_valid;
   logic       o_busy;
   logic       o_err;
   logic [1:0] o_err_code;
   logic       o_overrun;

   always #5 i_clk = ~i_clk;

   uart_cmd_ctrl #(
      .CLK_FREQ     (50000000),
      .CLK_PER_BIT  (CPB),
      .MAX_LEN      (MAXL),
      .TIMEOUT_BITS (TOB),
      .SYNC_BYTE    (8'hA5)
   ) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_rx_data   (i_rx_data),
      .i_rx_valid  (i_rx_valid),
      .o_reg_addr  (o_reg_addr),
      .o_reg_wdata (o_reg_wdata),
      .o_reg_we    (o_reg_we),
      .o_tx_data   (o_tx_data),
      .o_tx_valid  (o_tx_valid),
      .i_tx_ready  (i_tx_ready),
      .o_busy      (o_busy),
      .o_err       (o_err),
      .o_err_code  (o_err_code),
      .o_overrun   (o_overrun)
   );

   int          n_checks    = 0;
   int          n_errors    = 0;
   int          n_overrun   = 0;
   int          exp_overrun = 0;
   logic [15:0] q_wr  [$];
   logic [7:0]  q_tx  [$];
   logic [1:0]  q_err [$];
   logic [15:0] mon_wr;
   logic [7:0]  pl [16];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard monitor
   always @(negedge i_clk) begin
      if (!i_reset) begin
         if (o_reg_we) begin
            if (q_wr.size() == 0) begin
               check_eq("wr_unexpected", 1, 0);
            end else begin
               mon_wr = q_wr.pop_front();
               check_eq("wr_addr", o_reg_addr, mon_wr[15:8]);
               check_eq("wr_data", o_reg_wdata, mon_wr[7:0]);
            end
         end
         if (o_err) begin
            if (q_err.size() == 0) check_eq("err_unexpected", 1, 0);
            else                   check_eq("err_code", o_err_code, q_err.pop_front());
         end
         if (o_tx_valid && i_tx_ready) begin
            if (q_tx.size() == 0) check_eq("tx_unexpected", 1, 0);
            else                  check_eq("tx_byte", o_tx_data, q_tx.pop_front());
         end
         if (o_overrun) n_overrun++;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge i_clk); #1;
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      @(posedge i_clk); #1;
      i_rx_valid = 1'b0;
   endtask

   task automatic finish_resp(input int stall, input bit inject);
      int         n = 0;
      bit         stable = 1'b1;
      logic [7:0] d0;
      while (!o_tx_valid && n < 64) begin
         @(negedge i_clk);
         n++;
      end
      check_eq("resp_valid", o_tx_valid, 1);
      check_eq("resp_busy", o_busy, 1);
      d0 = o_tx_data;
      if (inject) begin
         send_byte(8'h5A);
         @(negedge i_clk);
         check_eq("overrun_pulse", o_overrun, 1);
         exp_overrun++;
      end
      repeat (stall) begin
         @(negedge i_clk);
         if (!o_tx_valid || o_tx_data != d0) stable = 1'b0;
      end
      check_eq("resp_stable", stable, 1);
      @(posedge i_clk); #1 i_tx_ready = 1'b1;
      @(posedge i_clk); #1 i_tx_ready = 1'b0;
      @(negedge i_clk);
      check_eq("resp_drop", o_tx_valid, 0);
      check_eq("idle_busy", o_busy, 0);
      check_eq("sb_empty", q_wr.size() + q_tx.size() + q_err.size(), 0);
   endtask

   // csum_adj != 0 corrupts the checksum byte that is sent.
   task automatic run_frame(input logic [7:0] addr, input logic [7:0] len,
                            input logic [7:0] p [16], input logic [7:0] csum_adj,
                            input int stall, input bit inject);
      logic [7:0] cs;
      logic [7:0] a;
      cs = addr ^ len;
      send_byte(8'hA5);
      send_byte(addr);
      if (len == 8'd0 || len > 8'(MAXL)) begin
         q_err.push_back(2'd1);
         q_tx.push_back(8'h15);
         send_byte(len);
         @(negedge i_clk);
         check_eq("nak_len_lat", o_tx_valid, 1);
         check_eq("nak_len_we", o_reg_we, 0);
      end else begin
         send_byte(len);
         for (int i = 0; i < int'(len); i++) begin
            cs = cs ^ p[i];
            send_byte(p[i]);
         end
         if (csum_adj == 8'd0) begin
            for (int i = 0; i < int'(len); i++) begin
               a = addr + 8'(i);
               q_wr.push_back({a, p[i]});
            end
            q_tx.push_back(8'h06);
            send_byte(cs);
            for (int k = 0; k < int'(len); k++) begin
               @(negedge i_clk);
               check_eq("we_burst", o_reg_we, 1);
            end
            @(negedge i_clk);
            check_eq("we_end", o_reg_we, 0);
            check_eq("ack_lat", o_tx_valid, 1);
         end else begin
            q_err.push_back(2'd2);
            q_tx.push_back(8'h15);
            send_byte(cs ^ csum_adj);
            @(negedge i_clk);
            check_eq("nak_csum_lat", o_tx_valid, 1);
            check_eq("nak_csum_we", o_reg_we, 0);
         end
      end
      finish_resp(stall, inject);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end

   initial begin
      int n;
      i_reset    = 1'b1;
      i_rx_data  = 8'd0;
      i_rx_valid = 1'b0;
      i_tx_ready = 1'b0;
      for (int i = 0; i < 16; i++) pl[i] = 8'd0;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      check_eq("rst_ctl", {o_busy, o_reg_we, o_tx_valid, o_err, o_overrun, o_err_code}, 0);
      check_eq("rst_data", {o_reg_addr, o_reg_wdata, o_tx_data}, 0);
      i_reset = 1'b0;

      // Non-SYNC bytes in IDLE are ignored
      send_byte(8'h00);
      send_byte(8'h10);
      send_byte(8'h06);
      @(negedge i_clk);
      check_eq("idle_junk_busy", o_busy, 0);

      pl[0] = 8'hAA; pl[1] = 8'hBB;
      run_frame(8'h10, 8'd2, pl, 8'h00, 5, 1'b0);     // CSUM 03 -> ACK
      run_frame(8'h10, 8'd2, pl, 8'h07, 3, 1'b0);     // CSUM 04 -> NAK
      run_frame(8'h20, 8'd0, pl, 8'h00, 2, 1'b0);     // LEN 0
      run_frame(8'h20, 8'h11, pl, 8'h00, 0, 1'b0);    // LEN 17
      pl[0] = 8'h01; pl[1] = 8'h02;
      run_frame(8'hFF, 8'd2, pl, 8'h00, 1, 1'b0);     // address wrap

      // Inter-byte timeout
      q_err.push_back(2'd3);
      send_byte(8'hA5);
      send_byte(8'h10);
      n = 0;
      while (q_err.size() != 0 && n < TO_CYC + 40) begin
         @(negedge i_clk);
         n++;
      end
      check_eq("to_fired", q_err.size(), 0);
      check_eq("to_window", (n >= TO_CYC - 4 && n <= TO_CYC + 4), 1);
      @(negedge i_clk);
      check_eq("to_idle", o_busy, 0);
      check_eq("to_no_tx", o_tx_valid, 0);
      pl[0] = 8'h3C;
      run_frame(8'h40, 8'd1, pl, 8'h00, 2, 1'b0);

      // Maximum length, long stall with an overrun byte injected
      for (int i = 0; i < 16; i++) pl[i] = 8'(i * 7 + 1);
      run_frame(8'hF8, 8'd16, pl, 8'h00, 100, 1'b1);

      // Async reset in the middle of DATA
      send_byte(8'hA5);
      send_byte(8'h30);
      send_byte(8'h03);
      send_byte(8'hAA);
      @(negedge i_clk);
      check_eq("pre_rst_busy", o_busy, 1);
      #2 i_reset = 1'b1;
      #1;
      check_eq("mid_rst_ctl", {o_busy, o_reg_we, o_tx_valid, o_err, o_overrun, o_err_code}, 0);
      check_eq("mid_rst_data", {o_reg_addr, o_reg_wdata, o_tx_data}, 0);
      repeat (2) @(negedge i_clk);
      i_reset = 1'b0;
      repeat (20) @(negedge i_clk);
      check_eq("post_rst_busy", o_busy, 0);
      pl[0] = 8'h99;
      run_frame(8'h55, 8'd1, pl, 8'h00, 0, 1'b0);

      check_eq("overrun_count", n_overrun, exp_overrun);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
